mem_bus_arbiter: RTL and testbench

Two-master round-robin arbiter that shares the data-memory bus (dmem plus memory-mapped peripheral) between the CPU load/store port (master 0) and a second requester such as a DMA or debug engine (master 1). It registers the winning master's address, write strobes and write data onto a single slave bus. It decodes the address into a one-hot chip enable (dmem or peripheral) and returns the selected slave's read data with a one-cycle ack. It sits between the CPU/DMA ports and the dmem/peripheral pair, replacing the purely combinational address/ce steering.

---
 rtl/mem_bus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master round-robin arbiter for the data-memory bus.
// Master 0 is the CPU load/store port, master 1 a DMA/debug requester.
// The winning request is registered onto a single slave bus. Its address is
// decoded into a one-hot chip enable (dmem / peripheral). The selected
// slave's synchronous read data returns with a one-cycle ack.
// Optional feature: define ARB_LOCK_EN to let a locked master keep the grant
// for up to MAX_BURST consecutive transactions.
module mem_bus_arbiter #(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int unsigned PER_BASE  = 32'h0000_0400,
    parameter int          MAX_BURST = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    // master 0 (CPU)
    input  logic              i_m0_req,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [3:0]        i_m0_we,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic              i_m0_lock,
    output logic              o_m0_ack,
    output logic [DATA_W-1:0] o_m0_rdata,
    // master 1 (DMA / debug)
    input  logic              i_m1_req,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [3:0]        i_m1_we,
    input  logic [DATA_W-1:0] i_m1_wdata,
    input  logic              i_m1_lock,
    output logic              o_m1_ack,
    output logic [DATA_W-1:0] o_m1_rdata,
    // slave bus
    output logic [1:0]        o_s_ce,
    output logic [ADDR_W-1:0] o_s_addr,
    output logic [3:0]        o_s_we,
    output logic [DATA_W-1:0] o_s_wdata,
    input  logic [DATA_W-1:0] i_s_rdata0,
    input  logic [DATA_W-1:0] i_s_rdata1,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] PER_BASE_A = ADDR_W'(PER_BASE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_gnt;      // master owning the current transaction
    logic              r_last;     // master granted most recently
    logic              r_sel_per;  // latched decode: 1 = peripheral
    logic [1:0]        r_ack;
    logic [1:0]        r_s_ce;
    logic [ADDR_W-1:0] r_s_addr;
    logic [3:0]        r_s_we;
    logic [DATA_W-1:0] r_s_wdata;

    logic [1:0]        w_req;
    logic              w_win;
    logic              w_lock_hit;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0]        w_we;
    logic [DATA_W-1:0] w_wdata;
    logic              w_dec_per;
    logic [DATA_W-1:0] w_rsel;

    assign w_req = {i_m1_req, i_m0_req};

`ifdef ARB_LOCK_EN
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    logic [BURST_W-1:0] r_burst;

    // Previous grantee keeps the bus while it holds lock and has burst budget left
    always_comb begin
        w_lock_hit = 1'b0;
        if (r_last) w_lock_hit = i_m1_req & i_m1_lock;
        else        w_lock_hit = i_m0_req & i_m0_lock;
        if (r_burst >= BURST_W'(MAX_BURST)) w_lock_hit = 1'b0;
    end

    // Count locked grants; any grant won by arbitration restarts the burst
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_burst <= '0;
        end else if (r_state == ST_IDLE && |w_req) begin
            if (w_lock_hit) r_burst <= r_burst + BURST_W'(1);
            else            r_burst <= '0;
        end
    end
`else
    logic w_unused_lock;

    // Lock inputs have no effect in this build
    assign w_unused_lock = ^{i_m0_lock, i_m1_lock, (MAX_BURST == 0)};
    assign w_lock_hit    = 1'b0;
`endif

    // Winner selection: lock override, then alternate on contention
    always_comb begin
        w_win = 1'b0;
        if (w_lock_hit)          w_win = r_last;
        else if (w_req == 2'b11) w_win = ~r_last;
        else                     w_win = w_req[1];
    end

    // Steer the winner's request and decode its address
    always_comb begin
        w_addr    = w_win ? i_m1_addr  : i_m0_addr;
        w_we      = w_win ? i_m1_we    : i_m0_we;
        w_wdata   = w_win ? i_m1_wdata : i_m0_wdata;
        w_dec_per = (w_addr >= PER_BASE_A);
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next state: every transaction is IDLE -> ACCESS -> RESP -> IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (|w_req) w_next = ST_ACCESS;
            ST_ACCESS: w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Slave bus, grant and ack registers; address/wdata hold between grants
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt     <= 1'b0;
            r_last    <= 1'b1;
            r_sel_per <= 1'b0;
            r_ack     <= 2'b00;
            r_s_ce    <= 2'b00;
            r_s_addr  <= '0;
            r_s_we    <= 4'h0;
            r_s_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_gnt     <= w_win;
                        r_sel_per <= w_dec_per;
                        r_s_ce    <= w_dec_per ? 2'b10 : 2'b01;
                        r_s_addr  <= w_addr;
                        r_s_we    <= w_we;
                        r_s_wdata <= w_wdata;
                    end
                end
                ST_ACCESS: begin
                    r_s_ce       <= 2'b00;
                    r_s_we       <= 4'h0;
                    r_ack[r_gnt] <= 1'b1;
                end
                ST_RESP: begin
                    r_ack  <= 2'b00;
                    r_last <= r_gnt;
                end
                default: begin
                    r_ack  <= 2'b00;
                    r_s_ce <= 2'b00;
                    r_s_we <= 4'h0;
                end
            endcase
        end
    end

    // Read data returns combinationally from whichever slave was decoded
    always_comb begin
        w_rsel = r_sel_per ? i_s_rdata1 : i_s_rdata0;
    end

    assign o_m0_ack   = r_ack[0];
    assign o_m1_ack   = r_ack[1];
    assign o_m0_rdata = r_ack[0] ? w_rsel : '0;
    assign o_m1_rdata = r_ack[1] ? w_rsel : '0;
    assign o_s_ce     = r_s_ce;
    assign o_s_addr   = r_s_addr;
    assign o_s_we     = r_s_we;
    assign o_s_wdata  = r_s_wdata;
    assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset values, reads and writes from
// each master, round-robin under contention, mid-transaction reset, decode
// boundary, and (when ARB_LOCK_EN is defined) locked bursts.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              m0_req, m1_req, m0_lock, m1_lock;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [3:0]        m0_we, m1_we;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_ack, m1_ack;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [1:0]        s_ce;
    logic [ADDR_W-1:0] s_addr;
    logic [3:0]        s_we;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W-1:0] s_rdata0 = '0;
    logic [DATA_W-1:0] s_rdata1 = '0;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_m0_req   (m0_req),
        .i_m0_addr  (m0_addr),
        .i_m0_we    (m0_we),
        .i_m0_wdata (m0_wdata),
        .i_m0_lock  (m0_lock),
        .o_m0_ack   (m0_ack),
        .o_m0_rdata (m0_rdata),
        .i_m1_req   (m1_req),
        .i_m1_addr  (m1_addr),
        .i_m1_we    (m1_we),
        .i_m1_wdata (m1_wdata),
        .i_m1_lock  (m1_lock),
        .o_m1_ack   (m1_ack),
        .o_m1_rdata (m1_rdata),
        .o_s_ce     (s_ce),
        .o_s_addr   (s_addr),
        .o_s_we     (s_we),
        .o_s_wdata  (s_wdata),
        .i_s_rdata0 (s_rdata0),
        .i_s_rdata1 (s_rdata1),
        .o_busy     (busy)
    );

    function automatic logic [31:0] dmem_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : {16'hD000, a[15:0]};
    endfunction

    function automatic logic [31:0] per_val(input logic [31:0] a);
        return {16'hB000, a[15:0]};
    endfunction

    // Synchronous slaves: data valid the cycle after their chip enable
    always @(posedge clk) begin
        if (s_ce[0]) s_rdata0 <= dmem_val(s_addr);
        if (s_ce[1]) s_rdata1 <= per_val(s_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction from IDLE for a single requester
    task automatic run_txn(input string nm, input int m, input logic [31:0] addr,
                           input logic [3:0] we, input logic [31:0] wd,
                           input logic [1:0] ce, input logic [31:0] rd);
        if (m == 0) begin
            m0_req = 1'b1; m0_addr = addr; m0_we = we; m0_wdata = wd;
        end else begin
            m1_req = 1'b1; m1_addr = addr; m1_we = we; m1_wdata = wd;
        end
        @(negedge clk);
        chk({nm, "_acc_ce"},    32'(s_ce),   32'(ce));
        chk({nm, "_acc_addr"},  s_addr,      addr);
        chk({nm, "_acc_we"},    32'(s_we),   32'(we));
        chk({nm, "_acc_wdata"}, s_wdata,     wd);
        chk({nm, "_acc_busy"},  32'(busy),   32'd1);
        chk({nm, "_acc_acks"},  32'({m1_ack, m0_ack}), 32'd0);
        @(negedge clk);
        chk({nm, "_rsp_ack"},    32'(m == 0 ? m0_ack : m1_ack), 32'd1);
        chk({nm, "_rsp_oack"},   32'(m == 0 ? m1_ack : m0_ack), 32'd0);
        chk({nm, "_rsp_rdata"},  (m == 0) ? m0_rdata : m1_rdata, rd);
        chk({nm, "_rsp_ordata"}, (m == 0) ? m1_rdata : m0_rdata, 32'd0);
        chk({nm, "_rsp_ce"},     32'(s_ce), 32'd0);
        chk({nm, "_rsp_we"},     32'(s_we), 32'd0);
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        chk({nm, "_idle_acks"}, 32'({m1_ack, m0_ack}), 32'd0);
        chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_we = 4'h0; m1_we = 4'h0;
        m0_wdata = '0; m1_wdata = '0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ce",    32'(s_ce),  32'd0);
        chk("rst_we",    32'(s_we),  32'd0);
        chk("rst_addr",  s_addr,     32'd0);
        chk("rst_wdata", s_wdata,    32'd0);
        chk("rst_acks",  32'({m1_ack, m0_ack}), 32'd0);
        chk("rst_rd0",   m0_rdata,   32'd0);
        chk("rst_rd1",   m1_rdata,   32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // m0 read from dmem, m1 write to peripheral
        run_txn("m0_rd", 0, 32'h10,  4'h0, 32'h0,         2'b01, 32'hDEAD_BEEF);
        run_txn("m1_wr", 1, 32'h400, 4'hF, 32'h1234_5678, 2'b10, 32'hB000_0400);

        // continuous contention: alternate starting with m0 (last grant was m1)
        m0_addr = 32'h20;  m0_we = 4'h0; m0_wdata = 32'h0;
        m1_addr = 32'h404; m1_we = 4'h0; m1_wdata = 32'h0;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_addr", i), s_addr, (i % 2 == 0) ? 32'h20 : 32'h404);
            chk($sformatf("rr%0d_busy_acc", i), 32'(busy), 32'd1);
            @(negedge clk);
            chk($sformatf("rr%0d_ack0", i), 32'(m0_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d_ack1", i), 32'(m1_ack), (i % 2 == 0) ? 32'd0 : 32'd1);
            chk($sformatf("rr%0d_rdata", i), (i % 2 == 0) ? m0_rdata : m1_rdata,
                (i % 2 == 0) ? 32'hD000_0020 : 32'hB000_0404);
            chk($sformatf("rr%0d_busy_rsp", i), 32'(busy), 32'd1);
            if (i == 5) begin
                m0_req = 1'b0; m1_req = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("rr%0d_busy_idle", i), 32'(busy), 32'd0);
        end

        // reset asserted during ACCESS drops the transaction
        m1_addr = 32'h30; m1_req = 1'b1;
        @(negedge clk);
        chk("mr_acc_ce", 32'(s_ce), 32'd1);
        rst_n = 1'b0;
        m1_req = 1'b0;
        #1;
        chk("mr_ce",    32'(s_ce),  32'd0);
        chk("mr_addr",  s_addr,     32'd0);
        chk("mr_busy",  32'(busy),  32'd0);
        chk("mr_acks",  32'({m1_ack, m0_ack}), 32'd0);
        chk("mr_rd1",   m1_rdata,   32'd0);
        @(negedge clk);
        chk("mr_noack_a", 32'({m1_ack, m0_ack}), 32'd0);
        @(negedge clk);
        chk("mr_noack_b", 32'({m1_ack, m0_ack}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_post_acks", 32'({m1_ack, m0_ack}), 32'd0);
        m0_addr = 32'h40; m1_addr = 32'h408;
        m0_req = 1'b1; m1_req = 1'b1;
        @(negedge clk);
        chk("mr_first_addr", s_addr, 32'h40);
        @(negedge clk);
        chk("mr_first_ack0", 32'(m0_ack), 32'd1);
        chk("mr_first_ack1", 32'(m1_ack), 32'd0);
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);

        // decode boundary
        run_txn("b3fc", 0, 32'h3FC,       4'h0, 32'h0, 2'b01, 32'hD000_03FC);
        run_txn("b400", 0, 32'h400,       4'h0, 32'h0, 2'b10, 32'hB000_0400);
        run_txn("bhi",  1, 32'h8000_0000, 4'h3, 32'hA5A5_5A5A, 2'b10, 32'hB000_0000);

`ifdef ARB_LOCK_EN
        // locked burst: m0 initial grant plus four locked grants, then m1
        run_txn("lk_pre", 1, 32'h0, 4'h0, 32'h0, 2'b01, 32'hD000_0000);
        m0_addr = 32'h50;  m0_we = 4'h0; m0_lock = 1'b1;
        m1_addr = 32'h40C; m1_we = 4'h0;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("lk%0d_addr", i), s_addr, (i < 5) ? 32'h50 : 32'h40C);
            @(negedge clk);
            chk($sformatf("lk%0d_ack0", i), 32'(m0_ack), (i < 5) ? 32'd1 : 32'd0);
            chk($sformatf("lk%0d_ack1", i), 32'(m1_ack), (i < 5) ? 32'd0 : 32'd1);
            if (i == 5) begin
                m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0;
            end
            @(negedge clk);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
